// File: rtl/elevator_door_fsm_if.sv
// -----------------------------------------------------------------------------
// elevator_door_fsm_if
// Bundles the request-side inputs and the motor/status outputs of one car door
// controller.
//   master : request logic / car sensors side (drives requests, sees status)
//   slave  : door controller side (elevator_door_fsm)
// Signals:
//   moving      car in motion
//   cur_floor   current floor index, 0-based
//   cur_dir     00 STOP, 10 UP, 01 DOWN, 11 illegal
//   hall_req    hall buttons at cur_floor: [1] up, [0] down
//   car_req     in-car floor buttons, one per floor
//   open_btn    in-car door-open button
//   close_btn   in-car door-close button
//   obstruct    door-edge / light-curtain sensor
//   motor_open  drive door toward open
//   motor_close drive door toward closed
//   door_closed door fully closed
//   door_open   door fully open
//   serviced    1-cycle pulse when the door reaches fully open
//   fault       sticky moving-interlock fault
//   nudge       forced-close buzzer
// -----------------------------------------------------------------------------
interface elevator_door_fsm_if #(
  parameter int NUM_FLOORS = 7
) ();
  localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;

  logic                  moving;
  logic [FW-1:0]         cur_floor;
  logic [1:0]            cur_dir;
  logic [1:0]            hall_req;
  logic [NUM_FLOORS-1:0] car_req;
  logic                  open_btn;
  logic                  close_btn;
  logic                  obstruct;
  logic                  motor_open;
  logic                  motor_close;
  logic                  door_closed;
  logic                  door_open;
  logic                  serviced;
  logic                  fault;
  logic                  nudge;

  modport master (
    output moving, cur_floor, cur_dir, hall_req, car_req,
           open_btn, close_btn, obstruct,
    input  motor_open, motor_close, door_closed, door_open,
           serviced, fault, nudge
  );

  modport slave (
    input  moving, cur_floor, cur_dir, hall_req, car_req,
           open_btn, close_btn, obstruct,
    output motor_open, motor_close, door_closed, door_open,
           serviced, fault, nudge
  );
endinterface

// File: rtl/elevator_door_fsm.sv
// -----------------------------------------------------------------------------
// elevator_door_fsm
// Per-car door controller with modelled door travel time. Four phases
// (CLOSED, OPENING, OPEN, CLOSING) share one down-counter. Obstruction or the
// open button reverses a closing door, retracing the distance already
// travelled. Motion of the car with the door not closed raises a sticky fault
// and forces the door state back to CLOSED.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    elevator_door_fsm_if.slave (requests in, motor/status out)
//
// Optional feature, macro ELEVATOR_DOOR_NUDGE_EN:
//   defined   : after MAX_REOPEN obstruction reopens, the next CLOSING phase
//               ignores obstruct (open_btn still reverses) and drives nudge.
//   undefined : unlimited obstruction reopens, nudge held at 0.
//
// All outputs are registered; they are decoded from the next-state values so
// they line up with the state register in the same cycle.
// -----------------------------------------------------------------------------
module elevator_door_fsm #(
  parameter int NUM_FLOORS   = 7,
  parameter int MOVE_CYCLES  = 4,
  parameter int DWELL_CYCLES = 10,
  parameter int MAX_REOPEN   = 3
) (
  input  logic               clk,
  input  logic               reset,
  elevator_door_fsm_if.slave bus
);

  localparam int FW   = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int CMAX = (MOVE_CYCLES > DWELL_CYCLES) ? MOVE_CYCLES : DWELL_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int RW   = (MAX_REOPEN > 0) ? $clog2(MAX_REOPEN + 1) : 1;

  localparam logic [CW-1:0] MOVE_LOAD  = CW'(MOVE_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [RW-1:0] REOPEN_MAX = RW'(MAX_REOPEN);
  localparam logic [RW-1:0] REOPEN_ONE = RW'(1);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'b00,
    ST_OPENING = 2'b01,
    ST_OPEN    = 2'b10,
    ST_CLOSING = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] reopen_q, reopen_d;
  logic          fault_q, fault_d;
  logic          motor_open_q, motor_close_q, door_closed_q, door_open_q;
  logic          serviced_q, nudge_q, nudge_d;

  logic          car_hit;
  logic          hall_hit;
  logic          trig;
  logic          obstruct_eff;

  // Door request decode: car button at this floor, open button, or a hall
  // button matching the direction of travel.
  always_comb begin
    car_hit = 1'b0;
    // Out-of-range floor index matches no car button.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (bus.cur_floor == FW'(i)) begin
        car_hit = car_hit | bus.car_req[i];
      end else begin
        car_hit = car_hit;
      end
    end

    case (bus.cur_dir)
      2'b00:   hall_hit = |bus.hall_req;
      2'b10:   hall_hit = bus.hall_req[1];
      2'b01:   hall_hit = bus.hall_req[0];
      default: hall_hit = 1'b0;
    endcase

    trig = car_hit | bus.open_btn | hall_hit;

`ifdef ELEVATOR_DOOR_NUDGE_EN
    // Once the reopen budget is spent, obstruct no longer reverses the door.
    obstruct_eff = bus.obstruct & (reopen_q != REOPEN_MAX);
`else
    obstruct_eff = bus.obstruct;
`endif
  end

  // Next-state, counter, reopen count and fault logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reopen_d = reopen_q;
    fault_d  = fault_q;

    if (bus.moving && (state_q != ST_CLOSED)) begin
      // Interlock: car moving with door not closed.
      fault_d = 1'b1;
      state_d = ST_CLOSED;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_CLOSED: begin
          if (trig && !bus.moving) begin
            state_d = ST_OPENING;
            cnt_d   = MOVE_LOAD;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        ST_OPENING: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = ST_OPEN;
            cnt_d   = DWELL_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_OPEN: begin
          if (bus.obstruct || bus.open_btn) begin
            cnt_d = DWELL_LOAD;
          end else if (bus.close_btn || (cnt_q == CNT_ZERO)) begin
            state_d = ST_CLOSING;
            cnt_d   = MOVE_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_CLOSING: begin
          if (obstruct_eff || bus.open_btn) begin
            // Reopen from the current position: remaining open travel equals
            // the closing travel already done.
            state_d = ST_OPENING;
            cnt_d   = MOVE_LOAD - cnt_q;
            if (obstruct_eff && (reopen_q != REOPEN_MAX)) begin
              reopen_d = reopen_q + REOPEN_ONE;
            end else begin
              reopen_d = reopen_q;
            end
          end else if (cnt_q == CNT_ZERO) begin
            state_d = ST_CLOSED;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_CLOSED;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // The reopen budget is per door cycle: refill whenever the door closes.
    if ((state_d == ST_CLOSED) && (state_q != ST_CLOSED)) begin
      reopen_d = {RW{1'b0}};
    end else begin
      reopen_d = reopen_d;
    end

`ifdef ELEVATOR_DOOR_NUDGE_EN
    nudge_d = (state_d == ST_CLOSING) && (reopen_d == REOPEN_MAX);
`else
    nudge_d = 1'b0;
`endif
  end

  // State, counter and registered output update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLOSED;
      cnt_q         <= CNT_ZERO;
      reopen_q      <= {RW{1'b0}};
      fault_q       <= 1'b0;
      motor_open_q  <= 1'b0;
      motor_close_q <= 1'b0;
      door_closed_q <= 1'b1;
      door_open_q   <= 1'b0;
      serviced_q    <= 1'b0;
      nudge_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reopen_q      <= reopen_d;
      fault_q       <= fault_d;
      motor_open_q  <= (state_d == ST_OPENING);
      motor_close_q <= (state_d == ST_CLOSING);
      door_closed_q <= (state_d == ST_CLOSED);
      door_open_q   <= (state_d == ST_OPEN);
      serviced_q    <= (state_q == ST_OPENING) && (state_d == ST_OPEN);
      nudge_q       <= nudge_d;
    end
  end

  assign bus.motor_open  = motor_open_q;
  assign bus.motor_close = motor_close_q;
  assign bus.door_closed = door_closed_q;
  assign bus.door_open   = door_open_q;
  assign bus.serviced    = serviced_q;
  assign bus.fault       = fault_q;
  assign bus.nudge       = nudge_q;

endmodule
